// File: rtl/lfsr_pkg.sv
// Shared definitions for the 16-bit XNOR data LFSR (taps 15,14,12,3; shift left, new bit into [0]).
// Used by both the generator and the receive-side checker so the polynomial is defined once.
package lfsr_pkg;

  localparam logic [15:0] LFSR16_TAPS   = 16'hD008;
  localparam logic [15:0] LFSR16_LOCKUP = 16'hFFFF;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } chk_state_t;

  // XNOR feedback: the all-ones register is the only state that maps onto itself.
  function automatic logic lfsr16_next_bit(input logic [15:0] s);
    return ~(^(s & LFSR16_TAPS));
  endfunction

endpackage

// File: rtl/lfsr16_checker_if.sv
// Received bit stream in, lock/error status out; the checker is the slave side.
// No backpressure: bit_valid alone qualifies bit_in.
interface lfsr16_checker_if;

  logic        bit_in;
  logic        bit_valid;
  logic        err_clr;
  logic        locked;
  logic        bit_err;
  logic [15:0] err_count;
  logic [1:0]  state;

  modport master (
    output bit_in, bit_valid, err_clr,
    input  locked, bit_err, err_count, state
  );

  modport slave (
    input  bit_in, bit_valid, err_clr,
    output locked, bit_err, err_count, state
  );

endinterface

// File: rtl/lfsr16_predictor.sv
// Shift register holding the expected LFSR state; exp/lockup are combinational from sr.
// Shifts only when shift_en; sel=1 feeds back its own prediction (flywheel), sel=0 feeds bit_in.
module lfsr16_predictor
  import lfsr_pkg::*;
(
  input  logic CLK,
  input  logic reset,
  input  logic shift_en,
  input  logic sel,
  input  logic bit_in,
  output logic exp,
  output logic lockup
);

  logic [15:0] sr;

  assign exp    = lfsr16_next_bit(sr);
  assign lockup = (sr == LFSR16_LOCKUP);

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      sr <= '0;
    end else if (shift_en) begin
      sr <= {sr[14:0], sel ? exp : bit_in};
    end
  end

endmodule

// File: rtl/lfsr16_checker.sv
// Self-synchronising PRBS checker: HUNT fills the predictor, VERIFY confirms, LOCKED counts errors.
// Status/error outputs are registered, one cycle after the deciding valid bit; no backpressure.
module lfsr16_checker
  import lfsr_pkg::*;
#(
  parameter int unsigned LOCK_COUNT  = 32,
  parameter int unsigned WINDOW      = 64,
  parameter int unsigned LOSS_THRESH = 8
) (
  input  logic            CLK,
  input  logic            reset,
  lfsr16_checker_if.slave chk
);

  localparam logic [7:0] LOCK_N   = 8'(LOCK_COUNT);
  localparam logic [7:0] WINDOW_N = 8'(WINDOW);
  localparam logic [7:0] THRESH_N = 8'(LOSS_THRESH);

  chk_state_t  state_q, state_d;
  logic [4:0]  fill_cnt_q, fill_cnt_d, fill_inc;
  logic [7:0]  good_cnt_q, good_cnt_d, good_inc;
  logic [7:0]  win_cnt_q, win_cnt_d, win_cnt_inc;
  logic [7:0]  win_err_q, win_err_d, win_err_inc;
  logic [15:0] err_count_q;
  logic        bit_err_q;
  logic        exp, lockup, mismatch, lock_err, flywheel;

  assign flywheel    = (state_q == LOCKED);
  assign mismatch    = chk.bit_in ^ exp;
  assign lock_err    = chk.bit_valid & flywheel & mismatch;
  assign fill_inc    = fill_cnt_q + 5'd1;
  assign good_inc    = good_cnt_q + 8'd1;
  assign win_cnt_inc = win_cnt_q + 8'd1;
  assign win_err_inc = win_err_q + {7'd0, mismatch};

  lfsr16_predictor u_pred (
    .CLK      (CLK),
    .reset    (reset),
    .shift_en (chk.bit_valid),
    .sel      (flywheel),
    .bit_in   (chk.bit_in),
    .exp      (exp),
    .lockup   (lockup)
  );

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q    <= HUNT;
      fill_cnt_q <= '0;
      good_cnt_q <= '0;
      win_cnt_q  <= '0;
      win_err_q  <= '0;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
      good_cnt_q <= good_cnt_d;
      win_cnt_q  <= win_cnt_d;
      win_err_q  <= win_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    good_cnt_d = good_cnt_q;
    win_cnt_d  = win_cnt_q;
    win_err_d  = win_err_q;
    if (chk.bit_valid) begin
      unique case (state_q)
        HUNT: begin
          fill_cnt_d = fill_inc;
          if (fill_inc == 5'd16) begin
            state_d    = VERIFY;
            fill_cnt_d = '0;
            good_cnt_d = '0;
          end
        end
        VERIFY: begin
          // A stream that stuck at all-ones predicts itself perfectly; never lock on it.
          if (mismatch || (good_inc == LOCK_N && lockup)) begin
            state_d    = HUNT;
            fill_cnt_d = '0;
            good_cnt_d = '0;
          end else if (good_inc == LOCK_N) begin
            state_d    = LOCKED;
            good_cnt_d = '0;
            win_cnt_d  = '0;
            win_err_d  = '0;
          end else begin
            good_cnt_d = good_inc;
          end
        end
        LOCKED: begin
          win_cnt_d = win_cnt_inc;
          win_err_d = win_err_inc;
          if (win_err_inc == THRESH_N) begin
            state_d    = HUNT;
            fill_cnt_d = '0;
            good_cnt_d = '0;
            win_cnt_d  = '0;
            win_err_d  = '0;
          end else if (win_cnt_inc == WINDOW_N) begin
            win_cnt_d = '0;
            win_err_d = '0;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // Clear takes priority, but an error on the same edge still counts.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      err_count_q <= '0;
      bit_err_q   <= 1'b0;
    end else begin
      bit_err_q <= lock_err;
      if (chk.err_clr) begin
        err_count_q <= {15'd0, lock_err};
      end else if (lock_err && err_count_q != 16'hFFFF) begin
        err_count_q <= err_count_q + 16'd1;
      end
    end
  end

  always_comb begin
    chk.locked    = (state_q == LOCKED);
    chk.state     = state_q;
    chk.bit_err   = bit_err_q;
    chk.err_count = err_count_q;
  end

endmodule
